// File: rtl/adc_sample_capture.sv
// adc_sample_capture: periodic SPI read of an AD7476-style ADC with a valid/ready sample output
module adc_sample_capture #(
    parameter int CLK_DIV       = 2,
    parameter int SAMPLE_PERIOD = 100,
    parameter int LEAD_BITS     = 4,
    parameter int DATA_W        = 12
) (
    input  logic              sys_clk_i,
    input  logic              sys_rst_i,
    input  logic              en_i,
    output logic              adc_cs_n_o,
    output logic              adc_sclk_o,
    input  logic              adc_sdata_i,
    output logic [DATA_W-1:0] sample_o,
    output logic              sample_valid_o,
    input  logic              sample_ready_i,
    output logic              overrun_o,
    input  logic              ovr_clr_i
);
    localparam int FB = LEAD_BITS + DATA_W;
    localparam int CW = $clog2(SAMPLE_PERIOD);
    localparam int DW = $clog2(CLK_DIV + 1);
    localparam int BW = $clog2(FB);
    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] div_q, div_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [DATA_W-1:0] shreg_q, shreg_d, sample_q, sample_d;
    logic sclk_q, sclk_d, cs_n_q, cs_n_d, valid_q, valid_d, ovr_q, ovr_d;
    logic tick, last, load;
    assign tick = en_i && cnt_q == CW'(SAMPLE_PERIOD - 1);
    assign last = div_q == DW'(CLK_DIV - 1);
    always_comb begin
        cnt_d   = (!en_i || tick) ? '0 : cnt_q + CW'(1);
        state_d = state_q;
        div_d   = last ? '0 : div_q + DW'(1);
        bit_d   = bit_q;
        sclk_d  = sclk_q;
        cs_n_d  = cs_n_q;
        shreg_d = shreg_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                div_d = '0;
                if (tick) begin
                    state_d = SETUP;
                    cs_n_d  = 1'b0;
                end
            end
            SETUP: if (last) begin
                state_d = SHIFT;
                sclk_d  = 1'b0;
                bit_d   = '0;
            end
            SHIFT: if (last) begin
                // leading bits shift out of the top of the DATA_W-wide register
                if (!sclk_q) begin
                    sclk_d  = 1'b1;
                    shreg_d = {shreg_q[DATA_W-2:0], adc_sdata_i};
                end else if (bit_q == BW'(FB - 1)) begin
                    state_d = HOLD;
                end else begin
                    sclk_d = 1'b0;
                    bit_d  = bit_q + BW'(1);
                end
            end
            HOLD: if (last) begin
                state_d = IDLE;
                cs_n_d  = 1'b1;
                load    = 1'b1;
            end
        endcase
        sample_d = load ? shreg_q : sample_q;
        valid_d  = load | (valid_q & ~sample_ready_i);
        ovr_d    = (load & valid_q & ~sample_ready_i) | (ovr_q & ~ovr_clr_i);
    end
    always_ff @(posedge sys_clk_i) begin
        if (!sys_rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            div_q    <= '0;
            bit_q    <= '0;
            sclk_q   <= 1'b1;
            cs_n_q   <= 1'b1;
            shreg_q  <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            sclk_q   <= sclk_d;
            cs_n_q   <= cs_n_d;
            shreg_q  <= shreg_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
            ovr_q    <= ovr_d;
        end
    end
    assign adc_cs_n_o     = cs_n_q;
    assign adc_sclk_o     = sclk_q;
    assign sample_o       = sample_q;
    assign sample_valid_o = valid_q;
    assign overrun_o      = ovr_q;
endmodule

// File: tb/tb_adc_sample_capture.sv
// tb_adc_sample_capture: ADC frame model with a scoreboard of expected samples plus directed steps
module tb_adc_sample_capture;
    logic clk = 1'b0, rst = 1'b0, en = 1'b0, sdata = 1'b0, ready = 1'b1, clr = 1'b0;
    logic cs_n, sclk, valid, ovr;
    logic [11:0] sample;
    int tests = 0, fails = 0;
    logic [15:0] frames[$];
    logic [11:0] exp_q[$];
    logic [15:0] cur = 16'h0;
    int idx = 0, falls = 0, low = 0, n = 0, quiet = 0;
    logic prev_cs = 1'b1;

    adc_sample_capture dut (
        .sys_clk_i(clk), .sys_rst_i(rst), .en_i(en),
        .adc_cs_n_o(cs_n), .adc_sclk_o(sclk), .adc_sdata_i(sdata),
        .sample_o(sample), .sample_valid_o(valid), .sample_ready_i(ready),
        .overrun_o(ovr), .ovr_clr_i(clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cs_fall(output int c);
        c = 0;
        do begin @(negedge clk); c++; end while (cs_n && c < 1000);
    endtask

    task automatic wait_cs_rise(output int c);
        c = 0;
        do begin @(negedge clk); c++; end while (!cs_n && c < 1000);
    endtask

    task automatic wait_valid(output int c);
        c = 0;
        do begin @(negedge clk); c++; end while (!valid && c < 1000);
    endtask

    // ADC model: next frame starts on CS fall, each bit launched on an SCLK falling edge
    always @(negedge cs_n) begin
        cur = frames.size() > 0 ? frames.pop_front() : 16'h0555;
        exp_q.push_back(cur[11:0]);
        idx = 15;
        falls = 0;
    end

    always @(negedge sclk) begin
        if (!cs_n) begin
            falls++;
            if (idx >= 0) begin
                sdata = cur[idx[3:0]];
                idx--;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            low = 0;
            prev_cs = 1'b1;
        end else begin
            if (!cs_n) low++;
            if (cs_n && !prev_cs) begin
                check("frame_len", low, 68);
                check("sclk_falls", falls, 16);
                check("sb_nonempty", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) check("sb_sample", 32'(sample), 32'(exp_q.pop_front()));
                check("sb_valid", 32'(valid), 1);
                low = 0;
            end
            prev_cs = cs_n;
        end
    end

    initial begin
        frames = {16'h0ABC, 16'h0FFF, 16'h0000, 16'hF123, 16'h0111, 16'h0222,
                  16'h0333, 16'h0ABC, 16'h0444, 16'h0555};
        repeat (3) @(negedge clk);
        check("rst_cs_n", 32'(cs_n), 1);
        check("rst_sclk", 32'(sclk), 1);
        check("rst_sample", 32'(sample), 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_ovr", 32'(ovr), 0);
        en = 1'b1;
        rst = 1'b1;
        wait_cs_fall(n);
        check("t1_tick", n, 100);
        wait_valid(n);
        check("t1_latency", n, 68);
        check("t1_sample", 32'(sample), 'hABC);
        @(negedge clk);
        check("t1_pulse", 32'(valid), 0);
        wait_valid(n);
        check("t2_fff", 32'(sample), 'hFFF);
        wait_valid(n);
        check("t2_000", 32'(sample), 'h000);
        check("t2_000_wait", 32'(n < 1000), 1);
        wait_valid(n);
        check("t2_lead_ones", 32'(sample), 'h123);
        @(negedge clk);
        ready = 1'b0;
        wait_valid(n);
        check("t3_first", 32'(sample), 'h111);
        check("t3_first_ovr", 32'(ovr), 0);
        wait_cs_fall(n);
        wait_cs_rise(n);
        check("t3_sample", 32'(sample), 'h222);
        check("t3_valid", 32'(valid), 1);
        check("t3_ovr", 32'(ovr), 1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("t3_clr", 32'(ovr), 0);
        check("t3_keep_valid", 32'(valid), 1);
        check("t3_keep_sample", 32'(sample), 'h222);
        wait_cs_fall(n);
        repeat (67) @(negedge clk);
        ready = 1'b1;
        @(negedge clk);
        check("t4_valid", 32'(valid), 1);
        check("t4_sample", 32'(sample), 'h333);
        check("t4_ovr", 32'(ovr), 0);
        @(negedge clk);
        check("t4_accept", 32'(valid), 0);
        wait_cs_fall(n);
        repeat (30) @(negedge clk);
        check("t5_bit7_sclk", 32'(sclk), 0);
        rst = 1'b0;
        @(negedge clk);
        check("t5_cs_n", 32'(cs_n), 1);
        check("t5_sclk", 32'(sclk), 1);
        check("t5_valid", 32'(valid), 0);
        check("t5_sample", 32'(sample), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        wait_cs_fall(n);
        check("t5_tick", n, 100);
        repeat (10) @(negedge clk);
        en = 1'b0;
        wait_valid(n);
        check("t6_sample", 32'(sample), 'h444);
        repeat (300) begin
            @(negedge clk);
            if (!cs_n) quiet++;
        end
        check("t6_quiet", quiet, 0);
        en = 1'b1;
        wait_cs_fall(n);
        check("t6_tick", n, 100);
        wait_valid(n);
        check("t6_resume", 32'(sample), 'h555);
        @(negedge clk);
        check("sb_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
